// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI bus master: one byte per frame, CS framing, COPI on rising / sample on falling
module spi_controller #(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_SETUP_CLKS     = 2,
    parameter int CS_HOLD_CLKS      = 2,
    parameter int CS_IDLE_CLKS      = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_hold_cs,
    output logic       o_tx_ready,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_spi_clk,
    output logic       o_spi_copi,
    input  logic       i_spi_cipo,
    output logic       o_spi_cs_n
);
    localparam int CW = 16;
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CLKS - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CLKS - 1);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_WAIT_NEXT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_edge_cnt;
    logic [7:0]    r_tx_shift;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_byte;
    logic          r_hold;
    logic          r_spi_clk;
    logic          r_cs_n;
    logic          r_ready;
    logic          r_rx_dv;
    logic          w_accept;
    logic          w_half_done;
    logic          w_last_edge;
    logic          w_timed_state;

    assign w_accept      = i_tx_dv && (r_state == S_IDLE || r_state == S_WAIT_NEXT);
    assign w_half_done   = (r_state == S_XFER) && (r_cnt == HALF_LAST);
    assign w_last_edge   = w_half_done && (r_edge_cnt == 4'd15);
    assign w_timed_state = (r_state == S_SETUP) || (r_state == S_XFER) ||
                           (r_state == S_HOLD)  || (r_state == S_GAP);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (i_tx_dv) w_next = S_SETUP;
            S_SETUP:     if (r_cnt == SETUP_LAST) w_next = S_XFER;
            S_XFER:      if (w_last_edge) w_next = r_hold ? S_WAIT_NEXT : S_HOLD;
            S_WAIT_NEXT: if (i_tx_dv) w_next = S_XFER;
            S_HOLD:      if (r_cnt == HOLD_LAST) w_next = S_GAP;
            S_GAP:       if (r_cnt == IDLE_LAST) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so CS and ready never glitch on state decode.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt      <= '0;
            r_edge_cnt <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_hold     <= 1'b0;
            r_spi_clk  <= 1'b0;
            r_cs_n     <= 1'b1;
            r_ready    <= 1'b1;
            r_rx_dv    <= 1'b0;
        end else begin
            r_rx_dv <= w_last_edge;
            r_cs_n  <= (w_next == S_IDLE) || (w_next == S_GAP);
            r_ready <= (w_next == S_IDLE) || (w_next == S_WAIT_NEXT);

            if (w_next != r_state || w_half_done || !w_timed_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_accept) begin
                r_tx_shift <= i_tx_byte;
                r_hold     <= i_tx_hold_cs;
                r_edge_cnt <= '0;
            end

            if (w_half_done) begin
                r_spi_clk  <= ~r_spi_clk;
                r_edge_cnt <= r_edge_cnt + 4'd1;
                // Even count = rising edge; the first rising edge leaves bit 7 on COPI.
                if (!r_edge_cnt[0]) begin
                    if (r_edge_cnt != 4'd0) begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end
                end else begin
                    r_rx_shift <= {r_rx_shift[6:0], i_spi_cipo};
                    if (w_last_edge) begin
                        r_rx_byte <= {r_rx_shift[6:0], i_spi_cipo};
                    end
                end
            end
        end
    end

    assign o_tx_ready = r_ready;
    assign o_rx_dv    = r_rx_dv;
    assign o_rx_byte  = r_rx_byte;
    assign o_spi_clk  = r_spi_clk;
    assign o_spi_copi = r_tx_shift[7];
    assign o_spi_cs_n = r_cs_n;

endmodule
